// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single reg_file write port between an ALU write-back
//            requester (0) and a long-latency load/mul-div requester (1).
//            Keeps a busy scoreboard of long-latency destinations and flags
//            decode-stage RAW hazards until the pending result is written.
// Ports    : clk, rst_n          - clock, async active-low reset
//            wb0_* / wb1_*       - valid/ready write-back requesters
//            issue_valid/idx     - long-latency issue, marks destination busy
//            issue_err           - 1-cycle pulse: issue to a busy register
//            rs_idx/rt_idx       - decode source indices; hazard output
//            RegWrite/write_idx/write_data - registered reg_file write port
//            busy_vec            - scoreboard contents (debug)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb0_valid,
    input  logic [4:0]      wb0_idx,
    input  logic [DW-1:0]   wb0_data,
    output logic            wb0_ready,
    input  logic            wb1_valid,
    input  logic [4:0]      wb1_idx,
    input  logic [DW-1:0]   wb1_data,
    output logic            wb1_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_idx,
    output logic            issue_err,
    input  logic [4:0]      rs_idx,
    input  logic [4:0]      rt_idx,
    output logic            hazard,
    output logic            RegWrite,
    output logic [4:0]      write_idx,
    output logic [DW-1:0]   write_data,
    output logic [NREG-1:0] busy_vec
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic            rr_q,        rr_d;
    logic            src_q,       src_d;
    logic            regwrite_q,  regwrite_d;
    logic [4:0]      widx_q,      widx_d;
    logic [DW-1:0]   wdata_q,     wdata_d;
    logic [NREG-1:0] busy_q,      busy_d;
    logic            ierr_q,      ierr_d;

    // ------------------------------------------------------------------------
    // Arbitration: ready depends only on the valids and the rr pointer
    // ------------------------------------------------------------------------
    logic            w_grant0;
    logic            w_grant1;
    logic            w_contend;
    logic [4:0]      w_sel_idx;
    logic [DW-1:0]   w_sel_data;

    always_comb begin
        w_contend  = wb0_valid && wb1_valid;
        w_grant0   = wb0_valid && (!wb1_valid || !rr_q);
        w_grant1   = wb1_valid && (!wb0_valid ||  rr_q);
        w_sel_idx  = w_grant1 ? wb1_idx  : wb0_idx;
        w_sel_data = w_grant1 ? wb1_data : wb0_data;
    end

    assign wb0_ready = w_grant0;
    assign wb1_ready = w_grant1;

    // ------------------------------------------------------------------------
    // Write port next state
    // ------------------------------------------------------------------------
    always_comb begin
        rr_d       = rr_q;
        src_d      = src_q;
        regwrite_d = 1'b0;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        // The pointer only moves when both requesters competed.
        if (w_contend) begin
            rr_d = ~rr_q;
        end
        if (w_grant0 || w_grant1) begin
            // Index 0 is accepted but never written.
            regwrite_d = (w_sel_idx != 5'd0);
            widx_d     = w_sel_idx;
            wdata_d    = w_sel_data;
            src_d      = w_grant1;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------------
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;

    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        // Bit 0 is never set, so busy[0] stays constant 0.
        for (int i = 1; i < NREG; i++) begin
            if (issue_valid && (issue_idx == 5'(i))) begin
                w_set_vec[i] = 1'b1;
            end
            // The clear lands on the same edge reg_file commits the data, so
            // the hazard drops exactly when the value becomes readable.
            if (regwrite_q && src_q && (widx_q == 5'(i))) begin
                w_clr_vec[i] = 1'b1;
            end
        end
        // Set is applied after clear so a coincident re-issue keeps the bit.
        busy_d = (busy_q & ~w_clr_vec) | w_set_vec;
        // A register whose pending result retires on this edge is free, so a
        // coincident re-issue is legitimate and not reported.
        ierr_d = issue_valid && (issue_idx != 5'd0) &&
                 busy_q[issue_idx] && !w_clr_vec[issue_idx];
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            src_q      <= 1'b0;
            regwrite_q <= 1'b0;
            widx_q     <= 5'd0;
            wdata_q    <= '0;
            busy_q     <= '0;
            ierr_q     <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            src_q      <= src_d;
            regwrite_q <= regwrite_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            ierr_q     <= ierr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign RegWrite   = regwrite_q;
    assign write_idx  = widx_q;
    assign write_data = wdata_q;
    assign busy_vec   = busy_q;
    assign issue_err  = ierr_q;
    assign hazard     = ((rs_idx != 5'd0) && busy_q[rs_idx]) ||
                        ((rt_idx != 5'd0) && busy_q[rt_idx]);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NREG = 32;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb0_valid;
    logic [4:0]      wb0_idx;
    logic [DW-1:0]   wb0_data;
    logic            wb0_ready;
    logic            wb1_valid;
    logic [4:0]      wb1_idx;
    logic [DW-1:0]   wb1_data;
    logic            wb1_ready;
    logic            issue_valid;
    logic [4:0]      issue_idx;
    logic            issue_err;
    logic [4:0]      rs_idx;
    logic [4:0]      rt_idx;
    logic            hazard;
    logic            RegWrite;
    logic [4:0]      write_idx;
    logic [DW-1:0]   write_data;
    logic [NREG-1:0] busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.NREG(NREG), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb0_valid   (wb0_valid),
        .wb0_idx     (wb0_idx),
        .wb0_data    (wb0_data),
        .wb0_ready   (wb0_ready),
        .wb1_valid   (wb1_valid),
        .wb1_idx     (wb1_idx),
        .wb1_data    (wb1_data),
        .wb1_ready   (wb1_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_err   (issue_err),
        .rs_idx      (rs_idx),
        .rt_idx      (rt_idx),
        .hazard      (hazard),
        .RegWrite    (RegWrite),
        .write_idx   (write_idx),
        .write_data  (write_data),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    // Return 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        wb0_valid   = 1'b1;
        wb0_idx     = 5'd5;
        wb0_data    = 32'h42;
        wb1_valid   = 1'b0;
        wb1_idx     = 5'd0;
        wb1_data    = '0;
        issue_valid = 1'b0;
        issue_idx   = 5'd0;
        rs_idx      = 5'd0;
        rt_idx      = 5'd0;

        // Reset held two cycles while wb0 is requesting
        tick();
        tick();
        chk("rst_regwrite",  RegWrite,   1'b0);
        chk("rst_widx",      write_idx,  5'd0);
        chk("rst_wdata",     write_data, 32'h0);
        chk("rst_busy",      busy_vec,   32'h0);
        chk("rst_ierr",      issue_err,  1'b0);

        // Release: single write, requester 0 granted first
        rst_n = 1'b1;
        #1;
        chk("single_rdy0", wb0_ready, 1'b1);
        chk("single_rdy1", wb1_ready, 1'b0);
        tick();
        wb0_valid = 1'b0;
        chk("single_we",    RegWrite,   1'b1);
        chk("single_idx",   write_idx,  5'd5);
        chk("single_data",  write_data, 32'h42);
        tick();
        chk("single_we_off", RegWrite,   1'b0);
        chk("single_hold",   write_data, 32'h42);

        // Contention: rr starts at 0, alternates on each contended grant
        wb0_valid = 1'b1; wb0_idx = 5'd3; wb0_data = 32'hA;
        wb1_valid = 1'b1; wb1_idx = 5'd4; wb1_data = 32'hB;
        #1;
        chk("cont1_rdy0", wb0_ready, 1'b1);
        chk("cont1_rdy1", wb1_ready, 1'b0);
        tick();
        chk("cont1_idx", write_idx, 5'd3);
        chk("cont1_we",  RegWrite,  1'b1);
        wb0_idx = 5'd6; wb0_data = 32'hC;
        #1;
        chk("cont2_rdy0", wb0_ready, 1'b0);
        chk("cont2_rdy1", wb1_ready, 1'b1);
        tick();
        chk("cont2_idx",  write_idx,  5'd4);
        chk("cont2_data", write_data, 32'hB);
        wb1_idx = 5'd8; wb1_data = 32'hD;
        #1;
        chk("cont3_rdy0_rr0", wb0_ready, 1'b1);
        tick();
        chk("cont3_idx", write_idx, 5'd6);
        wb0_valid = 1'b0;
        #1;
        chk("cont4_rdy1", wb1_ready, 1'b1);
        tick();
        wb1_valid = 1'b0;
        chk("cont4_idx",  write_idx,  5'd8);
        chk("cont4_busy", busy_vec,   32'h0);
        tick();
        chk("cont_idle_we", RegWrite, 1'b0);

        // Scoreboard set / hazard / clear by requester 1
        issue_valid = 1'b1; issue_idx = 5'd10;
        tick();
        issue_valid = 1'b0;
        chk("sb_busy10", busy_vec,  32'h0000_0400);
        chk("sb_ierr0",  issue_err, 1'b0);
        rs_idx = 5'd10;
        #1;
        chk("sb_haz_rs", hazard, 1'b1);
        rs_idx = 5'd0; rt_idx = 5'd10;
        #1;
        chk("sb_haz_rt", hazard, 1'b1);
        rt_idx = 5'd0; rs_idx = 5'd10;
        wb1_valid = 1'b1; wb1_idx = 5'd10; wb1_data = 32'h12345678;
        #1;
        chk("sb_rdy1", wb1_ready, 1'b1);
        tick();
        wb1_valid = 1'b0;
        chk("sb_we",       RegWrite,   1'b1);
        chk("sb_data",     write_data, 32'h12345678);
        chk("sb_haz_hold", hazard,     1'b1);
        tick();
        chk("sb_haz_clr",  hazard,   1'b0);
        chk("sb_busy_clr", busy_vec, 32'h0);
        rs_idx = 5'd0;

        // Requester-0 write to a busy register leaves it busy
        issue_valid = 1'b1; issue_idx = 5'd12;
        tick();
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_idx = 5'd12; wb0_data = 32'h5;
        tick();
        wb0_valid = 1'b0;
        tick();
        chk("sb_r0_noclr", busy_vec, 32'h0000_1000);
        wb1_valid = 1'b1; wb1_idx = 5'd12; wb1_data = 32'h6;
        tick();
        wb1_valid = 1'b0;
        tick();
        chk("sb_r1_clr12", busy_vec, 32'h0);

        // Zero register
        wb1_valid = 1'b1; wb1_idx = 5'd0; wb1_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_idx = 5'd0;
        #1;
        chk("z_rdy1", wb1_ready, 1'b1);
        tick();
        wb1_valid = 1'b0; issue_valid = 1'b0;
        chk("z_we",   RegWrite, 1'b0);
        chk("z_busy", busy_vec, 32'h0);
        chk("z_haz",  hazard,   1'b0);
        tick();
        chk("z_ierr", issue_err, 1'b0);

        // Issue coincident with the clearing commit: set wins
        issue_valid = 1'b1; issue_idx = 5'd7;
        tick();
        issue_valid = 1'b0;
        wb1_valid = 1'b1; wb1_idx = 5'd7; wb1_data = 32'h77;
        tick();
        wb1_valid = 1'b0;
        chk("c7_we", RegWrite, 1'b1);
        issue_valid = 1'b1; issue_idx = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("c7_setwins", busy_vec, 32'h0000_0080);

        // Re-issue while busy: one-cycle error pulse
        issue_valid = 1'b1; issue_idx = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("c7_ierr_on",  issue_err, 1'b1);
        chk("c7_busy",     busy_vec,  32'h0000_0080);
        tick();
        chk("c7_ierr_off", issue_err, 1'b0);

        // Reset between acceptance and commit drops the write
        wb0_valid = 1'b1; wb0_idx = 5'd9; wb0_data = 32'h99;
        tick();
        wb0_valid = 1'b0;
        chk("mr_we_pre", RegWrite, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_we_async", RegWrite, 1'b0);
        chk("mr_busy",     busy_vec, 32'h0);
        tick();
        chk("mr_we_held", RegWrite, 1'b0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of reg_file between two write-back requesters:
  - requester 0: ALU, single-cycle results.
  - requester 1: load / multiply-divide unit, long-latency results.
- Tracks long-latency destinations in a 32-entry busy scoreboard and flags decode-stage RAW hazards until each pending result is actually written.
- Sits between the execute/memory stages and reg_file; drives reg_file's RegWrite, write_idx and write_data.

Parameters:
- NREG, 32, number of architectural registers (index width fixed at 5).
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wb0_valid  in  1  ALU write-back request.
- wb0_idx  in  5  ALU destination register.
- wb0_data  in  DW  ALU result.
- wb0_ready  out  1  ALU request accepted this cycle.
- wb1_valid  in  1  long-latency write-back request.
- wb1_idx  in  5  long-latency destination register.
- wb1_data  in  DW  long-latency result.
- wb1_ready  out  1  long-latency request accepted this cycle.
- issue_valid  in  1  long-latency op issued; mark destination pending.
- issue_idx  in  5  destination of issued op.
- issue_err  out  1  registered 1-cycle pulse: issue to an already-busy register.
- rs_idx  in  5  decode-stage source A index.
- rt_idx  in  5  decode-stage source B index.
- hazard  out  1  combinational: rs or rt is pending.
- RegWrite  out  1  to reg_file write enable.
- write_idx  out  5  to reg_file write index.
- write_data  out  DW  to reg_file write data.
- busy_vec  out  NREG  scoreboard contents, for debug.

Behaviour:

Reset (rst_n=0, async):
- RegWrite=0, write_idx=0, write_data=0.
- busy_vec=0, issue_err=0.
- Round-robin pointer rr=0 (requester 0 favoured first); internal source tag src=0.

Handshake:
- A transfer occurs when valid && ready on the same clk edge.
- Requesters hold valid, idx and data stable until ready.
- ready is combinational from the valid inputs and rr only. It never depends on the data inputs.

Arbitration:
- Exactly one grant per cycle.
- Only one valid: that requester is granted.
- Both valid: grant requester rr, then rr <= ~rr. rr changes only on a contended grant.
- Neither valid: both ready=0.

Write port:
- Registered; 1-cycle latency from acceptance.
- On the edge of acceptance:
  - RegWrite <= (granted idx != 0).
  - write_idx <= idx; write_data <= data; src <= granted requester number.
- Otherwise RegWrite <= 0; write_idx and write_data hold their values.
- reg_file captures the value on the following edge. Data is readable from the cycle after that edge.
- Writes to idx 0 are accepted (ready=1) but never assert RegWrite.

Scoreboard:
- set: issue_valid && issue_idx != 0 sets busy[issue_idx].
- clear: on an edge where RegWrite=1 && src=1, busy[write_idx] is cleared. This is the same edge on which reg_file commits the data, so hazard drops exactly when the data is readable.
- Set and clear to the same index on the same edge: set wins, busy stays 1.
- Issue to an index that is already busy: busy remains 1; issue_err=1 for one cycle.
- Requester-0 writes never clear busy.
- hazard = (rs_idx!=0 && busy[rs_idx]) || (rt_idx!=0 && busy[rt_idx]). busy[0] is constantly 0.

Reset mid-operation:
- All state clears immediately.
- An accepted but not yet committed write is dropped (RegWrite forced 0 asynchronously).

Test Plan:
- Reset: rst_n=0 for 2 cycles with wb0_valid=1 -> RegWrite=0, busy_vec=0, wb0_ready ignored. Release -> first grant goes to requester 0.
- Single write: wb0_valid=1, idx=5, data=32'h42 for 1 cycle -> wb0_ready=1. Next cycle RegWrite=1, write_idx=5, write_data=32'h42. Following cycle RegWrite=0.
- Contention: wb0 (idx=3, data=32'hA) and wb1 (idx=4, data=32'hB) held valid -> grant order req0, then req1. RegWrite sequence idx 3, 4 on consecutive cycles; rr returns to 0.
- Scoreboard: issue_valid idx=10, then rs_idx=10 -> hazard=1. wb1 writes idx 10 data=32'h12345678 -> hazard stays 1 through the RegWrite cycle and is 0 the cycle after, with busy_vec=0.
- Zero register: wb1 idx=0 data=32'hFFFFFFFF and issue_valid idx=0 -> wb1_ready=1, RegWrite stays 0, busy_vec=0. rs_idx=0 -> hazard=0.
- Corner cases:
  - issue idx=7 on the same edge that the requester-1 commit of idx 7 clears it -> busy[7]=1 afterwards.
  - issue idx=7 again while busy -> issue_err pulses for 1 cycle.
  - rst_n asserted between acceptance and commit -> no RegWrite.
